// File: rtl/hleaf_pkg.sv
// hleaf_pkg: shared routing helpers for the hleaf switch family.
// A route vector has one bit per leaf (bit k = leaf k) plus bit CENTRE for the uplink.
package hleaf_pkg;

  localparam int MAX_LEAF = 8;
  localparam int CENTRE   = MAX_LEAF;

  typedef logic [MAX_LEAF:0] route_t;

  localparam route_t CENTRE_SEL = route_t'(1) << CENTRE;

  // One-hot output select for a destination address: leaf if in range, otherwise centre.
  function automatic route_t route_decode(input int unsigned dest,
                                          input int unsigned base,
                                          input int unsigned num_leaf);
    route_t sel;
    if (dest >= base && dest < base + num_leaf) begin
      sel = route_t'(1) << (dest - base);
    end else begin
      sel = CENTRE_SEL;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hleaf_fifo.sv
// hleaf_fifo: per-input flit buffer with a combinational head. The head has to be
// visible in the cycle right after the write so the switch keeps its two-cycle path;
// depths are small, so the array maps onto distributed memory.
module hleaf_fifo #(
  parameter int Width = 36,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [Width-1:0] head_data,
  output logic             empty
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    wr_ptr_reg;
  logic [PtrW:0]    rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty; a push into a full FIFO is refused
  // even if a pop happens in the same cycle.
  assign full      = (wr_ptr_reg == {~rd_ptr_reg[PtrW], rd_ptr_reg[PtrW-1:0]});
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr_reg[PtrW-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers hide them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[PtrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hleaf_multi.sv
// hleaf_multi: leaf switch with NUM_LEAF leaf ports and one centre uplink.
// Each input is buffered in an hleaf_fifo; each output has its own round-robin
// arbiter feeding an output register. Centre flits addressed outside the leaf
// range are dropped. Define HLEAF_MULTI_DROP_CNT_EN to add the o_drop_count port.
module hleaf_multi
  import hleaf_pkg::*;
#(
  parameter int DataWidth  = 36,
  parameter int AddrWidth  = 4,
  parameter int NUM_LEAF   = 4,
  parameter int LEAF_BASE  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_sclk,
  input  logic                          i_reset,
`ifdef HLEAF_MULTI_DROP_CNT_EN
  output logic [15:0]                   o_drop_count,
`endif
  input  logic [NUM_LEAF*DataWidth-1:0] i_leaf_data,
  input  logic [NUM_LEAF-1:0]           i_leaf_data_valid,
  output logic [NUM_LEAF-1:0]           o_leaf_data_ready,
  output logic [NUM_LEAF*DataWidth-1:0] o_leaf_data,
  output logic [NUM_LEAF-1:0]           o_leaf_data_valid,
  input  logic [NUM_LEAF-1:0]           i_leaf_data_ready,
  input  logic [DataWidth-1:0]          i_centre_data,
  input  logic                          i_centre_data_valid,
  output logic                          o_centre_data_ready,
  output logic [DataWidth-1:0]          o_centre_data,
  output logic                          o_centre_data_valid,
  input  logic                          i_centre_data_ready
);

  localparam int NPORT = NUM_LEAF + 1;
  localparam int CIDX  = NUM_LEAF;        // port index of the centre uplink
  localparam int PtrW  = $clog2(NPORT);

  logic [DataWidth-1:0] head_data [NPORT];
  logic [NPORT-1:0]     fifo_empty;
  logic [NPORT-1:0]     fifo_pop;
  logic [NPORT-1:0]     drop;
  logic [NPORT-1:0]     route [NPORT];    // route[i][o]: head of input i targets output o
  logic [NPORT-1:0]     grant [NPORT];    // grant[o][i]: output o takes head of input i

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    logic [DataWidth-1:0] in_data;
    logic                 in_valid;
    logic                 in_full;
    logic                 out_ready;
    route_t               sel;
    logic [NPORT-1:0]     req;
    logic                 gnt_any;
    logic [PtrW-1:0]      gnt_idx;
    logic                 load;
    logic                 valid_reg;
    logic [DataWidth-1:0] data_reg;
    logic [PtrW-1:0]      ptr_reg;

    if (gi < NUM_LEAF) begin : g_leaf
      assign in_data                                = i_leaf_data[gi*DataWidth +: DataWidth];
      assign in_valid                               = i_leaf_data_valid[gi];
      assign out_ready                              = i_leaf_data_ready[gi];
      assign o_leaf_data_ready[gi]                  = ~in_full & ~i_reset;
      assign o_leaf_data[gi*DataWidth +: DataWidth] = data_reg;
      assign o_leaf_data_valid[gi]                  = valid_reg;
    end else begin : g_centre
      assign in_data             = i_centre_data;
      assign in_valid            = i_centre_data_valid;
      assign out_ready           = i_centre_data_ready;
      assign o_centre_data_ready = ~in_full & ~i_reset;
      assign o_centre_data       = data_reg;
      assign o_centre_data_valid = valid_reg;
    end

    hleaf_fifo #(
      .Width (DataWidth),
      .Depth (FIFO_DEPTH)
    ) u_fifo (
      .clk       (i_sclk),
      .srst      (i_reset),
      .push      (in_valid),
      .push_data (in_data),
      .full      (in_full),
      .pop       (fifo_pop[gi]),
      .head_data (head_data[gi]),
      .empty     (fifo_empty[gi])
    );

    // Input side: decode the head's destination. Centre-bound centre flits are dropped
    // instead of being routed back up the uplink.
    assign sel       = route_decode(32'(head_data[gi][DataWidth-1 -: AddrWidth]),
                                    LEAF_BASE, NUM_LEAF);
    assign route[gi] = {(gi != CIDX) && (sel == CENTRE_SEL), sel[NUM_LEAF-1:0]};
    assign drop[gi]  = (gi == CIDX) && (sel == CENTRE_SEL) && !fifo_empty[gi];

    // Output side: gather every non-empty head that targets this output.
    always_comb begin
      req = '0;
      for (int i = 0; i < NPORT; i++) req[i] = route[i][gi] & ~fifo_empty[i];
    end

    // Round-robin pick: first requester at or after the pointer, else wrap to the lowest.
    always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NPORT; i++) begin
        if (!gnt_any && req[i] && i >= int'(ptr_reg)) begin
          gnt_any = 1'b1;
          gnt_idx = PtrW'(i);
        end
      end
      for (int i = 0; i < NPORT; i++) begin
        if (!gnt_any && req[i]) begin
          gnt_any = 1'b1;
          gnt_idx = PtrW'(i);
        end
      end
    end

    // A grant only counts when the output register can take a new flit.
    assign load      = gnt_any && (!valid_reg || out_ready);
    assign grant[gi] = load ? (NPORT'(1) << gnt_idx) : '0;

    // Output register and arbiter pointer; held stable while stalled.
    always_ff @(posedge i_sclk) begin
      if (i_reset) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        ptr_reg   <= '0;
      end else if (load) begin
        valid_reg <= 1'b1;
        data_reg  <= head_data[gnt_idx];
        ptr_reg   <= (gnt_idx == PtrW'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  // Each head feeds at most one output, so OR-ing grants never pops a FIFO twice.
  always_comb begin
    fifo_pop = drop;
    for (int o = 0; o < NPORT; o++) fifo_pop = fifo_pop | grant[o];
  end

`ifdef HLEAF_MULTI_DROP_CNT_EN
  logic [15:0] drop_count_reg;

  // Saturating count of dropped centre flits.
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      drop_count_reg <= '0;
    end else if (drop[CIDX] && drop_count_reg != 16'hFFFF) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign o_drop_count = drop_count_reg;
`endif

endmodule
